// File: rtl/keccak_pkg.sv
// Shared widths and FSM state encoding for the masked Keccak sponge.
package keccak_pkg;
  localparam int LANE_W    = 64;
  localparam int STATE_W   = 1600;
  localparam int NUM_LANES = 25;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ABSORB  = 2'd1,
    PERM    = 2'd2,
    SQUEEZE = 2'd3
  } sponge_state_e;
endpackage

// File: rtl/keccak_lane_rw.sv
// Indexed lane access for one share: XOR a lane into the state and read a lane out.
module keccak_lane_rw
  import keccak_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [CNT_W-1:0]   idx,
  input  logic [LANE_W-1:0]  din,
  output logic [STATE_W-1:0] state_xor,
  output logic [LANE_W-1:0]  lane
);

  // Lane select by comparison keeps the index mux free of out-of-range slices.
  always_comb begin
    state_xor = state;
    lane      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx == CNT_W'(i)) begin
        state_xor[LANE_W*i +: LANE_W] = state[LANE_W*i +: LANE_W] ^ din;
        lane                          = state[LANE_W*i +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/keccak_masked_sponge.sv
// Two-share Keccak sponge front end: absorbs rate lanes, sequences an external
// permutation core via its reset, then squeezes OUT_LANES lanes per message.
//
// state   | meaning
// IDLE    | waiting for the first lane of a message, state registers zero
// ABSORB  | XORing lanes into the rate portion, cnt = next lane index
// PERM    | permutation core released (after one cycle), waiting for its result
// SQUEEZE | presenting lane cnt of each share until OUT_LANES lanes accepted
module keccak_masked_sponge
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  input  logic               in_last_i,
  input  logic [LANE_W-1:0]  in_share0_i,
  input  logic [LANE_W-1:0]  in_share1_i,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [LANE_W-1:0]  out_share0_o,
  output logic [LANE_W-1:0]  out_share1_o,
  output logic               perm_rst_n_o,
  output logic [STATE_W-1:0] perm_din_share0_o,
  output logic [STATE_W-1:0] perm_din_share1_o,
  input  logic [STATE_W-1:0] perm_dout_share0_i,
  input  logic [STATE_W-1:0] perm_dout_share1_i,
  input  logic               perm_dout_vld_i,
  output logic               busy_o
);

  sponge_state_e      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_q;
  logic               perm_rst_n_q;
  logic [STATE_W-1:0] st0_q, st1_q;
  logic [STATE_W-1:0] st0_xor, st1_xor;
  logic [LANE_W-1:0]  lane0, lane1;
  logic               in_fire, out_fire, blk_end;

  // Each share gets its own lane port so the shares never meet in one datapath.
  keccak_lane_rw u_rw0 (
    .state     (st0_q),
    .idx       (cnt_q),
    .din       (in_share0_i),
    .state_xor (st0_xor),
    .lane      (lane0)
  );

  keccak_lane_rw u_rw1 (
    .state     (st1_q),
    .idx       (cnt_q),
    .din       (in_share1_i),
    .state_xor (st1_xor),
    .lane      (lane1)
  );

  assign in_rdy_o          = (state_q == IDLE) || (state_q == ABSORB);
  assign out_vld_o         = (state_q == SQUEEZE);
  assign busy_o            = (state_q != IDLE);
  assign in_fire           = in_vld_i && in_rdy_o;
  assign out_fire          = out_vld_o && out_rdy_i;
  assign blk_end           = in_last_i || (cnt_q == CNT_W'(RATE_LANES - 1));
  assign out_share0_o      = lane0;
  assign out_share1_o      = lane1;
  assign perm_rst_n_o      = perm_rst_n_q;
  assign perm_din_share0_o = st0_q;
  assign perm_din_share1_o = st1_q;

  // Sponge sequencing: absorb, hand-off to the permutation core, squeeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      perm_rst_n_q <= 1'b0;
      st0_q        <= '0;
      st1_q        <= '0;
    end else begin
      case (state_q)
        IDLE, ABSORB: begin
          if (in_fire) begin
            st0_q <= st0_xor;
            st1_q <= st1_xor;
            if (in_last_i) last_q <= 1'b1;
            if (blk_end) begin
              cnt_q   <= '0;
              state_q <= PERM;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ABSORB;
            end
          end
        end
        PERM: begin
          // Core comes out of reset one cycle after entry; its valid only counts once released.
          if (!perm_rst_n_q) begin
            perm_rst_n_q <= 1'b1;
          end else if (perm_dout_vld_i) begin
            st0_q        <= perm_dout_share0_i;
            st1_q        <= perm_dout_share1_i;
            perm_rst_n_q <= 1'b0;
            state_q      <= last_q ? SQUEEZE : ABSORB;
          end
        end
        SQUEEZE: begin
          if (out_fire) begin
            if (cnt_q == CNT_W'(OUT_LANES - 1)) begin
              st0_q   <= '0;
              st1_q   <= '0;
              cnt_q   <= '0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_masked_sponge.sv
// Bench for keccak_masked_sponge: stubbed permutation, table vectors, scoreboard.
module tb_keccak_masked_sponge;
  localparam int RATE = 17;
  localparam int OUTL = 4;
  localparam logic [1599:0] PAT  = {200{8'hA5}};
  localparam logic [63:0]   PATL = {8{8'hA5}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld_i = 1'b0, in_last_i = 1'b0, out_rdy_i = 1'b0;
  logic [63:0]   in_share0_i = '0, in_share1_i = '0;
  logic          in_rdy_o, out_vld_o, perm_rst_n_o, busy_o;
  logic [63:0]   out_share0_o, out_share1_o;
  logic [1599:0] pdin0, pdin1;
  logic [1599:0] pd0 = '0, pd1 = '0;
  logic          stub_vld = 1'b0, force_vld = 1'b0;
  logic          perm_dout_vld;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] e0;
    logic [63:0] e1;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;
  vec_t tbl[4];

  logic [1599:0] m0 = '0, m1 = '0;
  int            mcnt = 0;

  always #5 clk = ~clk;

  keccak_masked_sponge #(.RATE_LANES(RATE), .OUT_LANES(OUTL)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_vld_i           (in_vld_i),
    .in_rdy_o           (in_rdy_o),
    .in_last_i          (in_last_i),
    .in_share0_i        (in_share0_i),
    .in_share1_i        (in_share1_i),
    .out_vld_o          (out_vld_o),
    .out_rdy_i          (out_rdy_i),
    .out_share0_o       (out_share0_o),
    .out_share1_o       (out_share1_o),
    .perm_rst_n_o       (perm_rst_n_o),
    .perm_din_share0_o  (pdin0),
    .perm_din_share1_o  (pdin1),
    .perm_dout_share0_i (pd0),
    .perm_dout_share1_i (pd1),
    .perm_dout_vld_i    (perm_dout_vld),
    .busy_o             (busy_o)
  );

  // Permutation stub: per-share XOR with 0xA5, valid 24 cycles after release.
  int pc = 0;
  always @(negedge clk) begin
    if (!perm_rst_n_o) begin
      pc       = 0;
      stub_vld = 1'b0;
    end else begin
      pc++;
      stub_vld = (pc == 24);
    end
    pd0 = pdin0 ^ PAT;
    pd1 = pdin1 ^ PAT;
  end
  assign perm_dout_vld = stub_vld | force_vld;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h req=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%b req=%b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d req=%0d", nm, act, exp);
    end
  endtask

  task automatic send_lane(input logic [63:0] a, input logic [63:0] b, input logic last, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) @(negedge clk);
    end
    in_share0_i = a;
    in_share1_i = b;
    in_last_i   = last;
    in_vld_i    = 1'b1;
    for (int k = 0; k < 100 && !in_rdy_o; k++) @(negedge clk);
    chk1("in_accept", in_rdy_o, 1'b1);
    @(negedge clk);
    in_vld_i  = 1'b0;
    in_last_i = 1'b0;
    m0[64*mcnt +: 64] = m0[64*mcnt +: 64] ^ a;
    m1[64*mcnt +: 64] = m1[64*mcnt +: 64] ^ b;
    mcnt = (last || mcnt == RATE - 1) ? 0 : mcnt + 1;
  endtask

  task automatic wait_perm();
    int hi;
    hi = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (perm_rst_n_o) hi++;
      else if (hi > 0) break;
    end
    chk_int("perm_hi_cycles", hi, 24);
    chk1("perm_rst_released", perm_rst_n_o, 1'b0);
    m0 = m0 ^ PAT;
    m1 = m1 ^ PAT;
  endtask

  task automatic model_push();
    exp_t e;
    for (int i = 0; i < OUTL; i++) begin
      e.e0 = m0[64*i +: 64];
      e.e1 = m1[64*i +: 64];
      sbq.push_back(e);
    end
    m0 = '0;
    m1 = '0;
    mcnt = 0;
  endtask

  task automatic recv_lane(input int hold);
    exp_t e;
    for (int k = 0; k < 100 && !out_vld_o; k++) @(negedge clk);
    chk1("out_vld", out_vld_o, 1'b1);
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_underflow act=empty req=entry");
      e.e0 = '0;
      e.e1 = '0;
    end else begin
      e = sbq.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk1("hold_vld", out_vld_o, 1'b1);
      chk64("hold_s0", out_share0_o, e.e0);
      chk64("hold_s1", out_share1_o, e.e1);
    end
    out_rdy_i = 1'b1;
    chk64("out_s0", out_share0_o, e.e0);
    chk64("out_s1", out_share1_o, e.e1);
    chk64("out_digest", out_share0_o ^ out_share1_o, e.e0 ^ e.e1);
    @(negedge clk);
    out_rdy_i = 1'b0;
  endtask

  task automatic recv_msg(input int hold_first, input bit rand_hold);
    for (int i = 0; i < OUTL; i++)
      recv_lane(rand_hold ? int'($urandom_range(0, 3)) : (i == 0 ? hold_first : 0));
    chk1("idle_busy", busy_o, 1'b0);
    chk1("idle_rdy", in_rdy_o, 1'b1);
    chk1("idle_state_zero", (pdin0 == '0) && (pdin1 == '0), 1'b1);
  endtask

  initial begin
    tbl[0] = '{64'h0000000000000006, 64'h0000000000000000, 64'hA5A5A5A5A5A5A5A3, 64'hA5A5A5A5A5A5A5A5};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 64'h5A5A5A5A5A5A5A5A, 64'hA486E0C22C0E684A};
    tbl[2] = '{64'h8000000000000001, 64'hA5A5A5A5A5A5A5A5, 64'h25A5A5A5A5A5A5A4, 64'h0000000000000000};
    tbl[3] = '{64'h0000000000000000, 64'h00000000000000FF, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A55A};

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_rdy", in_rdy_o, 1'b1);
    chk1("rst_out_vld", out_vld_o, 1'b0);
    chk1("rst_perm_rst", perm_rst_n_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_state_zero", (pdin0 == '0) && (pdin1 == '0), 1'b1);
    rst_n = 1'b1;
    #1;
    chk1("first_cycle_rdy", in_rdy_o, 1'b1);
    @(negedge clk);

    // Single-lane messages from the table
    for (int v = 0; v < 4; v++) begin
      exp_t e;
      send_lane(tbl[v].s0, tbl[v].s1, 1'b1, 1'b0);
      chk1("perm_rdy_low", in_rdy_o, 1'b0);
      chk1("perm_busy", busy_o, 1'b1);
      wait_perm();
      m0 = '0;
      m1 = '0;
      mcnt = 0;
      e.e0 = tbl[v].e0;
      e.e1 = tbl[v].e1;
      sbq.push_back(e);
      for (int i = 1; i < OUTL; i++) begin
        e.e0 = PATL;
        e.e1 = PATL;
        sbq.push_back(e);
      end
      recv_msg(0, 1'b0);
    end

    // Full block without last, then a last lane that must land in lane 0
    for (int i = 0; i < RATE; i++)
      send_lane({32'(i), 32'hC0DE0000 + 32'(i)}, {$urandom, $urandom}, 1'b0, 1'b0);
    chk1("blk_perm_rdy_low", in_rdy_o, 1'b0);
    wait_perm();
    chk1("absorb_rdy", in_rdy_o, 1'b1);
    chk1("absorb_perm_rst", perm_rst_n_o, 1'b0);
    chk1("absorb_busy", busy_o, 1'b1);
    chk1("absorb_out_vld", out_vld_o, 1'b0);
    repeat (5) @(negedge clk);
    chk1("absorb_idle_hold", (pdin0 == (m0 ^ '0)) && (pdin1 == m1), 1'b1);
    send_lane(64'h1122334455667788, 64'h99AABBCCDDEEFF00, 1'b1, 1'b0);
    wait_perm();
    model_push();
    recv_msg(10, 1'b0);

    // Reset in the middle of a permutation
    send_lane(64'h1, 64'h2, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (perm_rst_n_o && pc == 12) break;
    end
    chk_int("perm_cycle_12", pc, 12);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_busy", busy_o, 1'b0);
    chk1("mid_rst_perm_rst", perm_rst_n_o, 1'b0);
    chk1("mid_rst_rdy", in_rdy_o, 1'b1);
    chk1("mid_rst_state_zero", (pdin0 == '0) && (pdin1 == '0), 1'b1);
    m0 = '0;
    m1 = '0;
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    force_vld = 1'b1;
    repeat (2) @(negedge clk);
    force_vld = 1'b0;
    chk1("late_vld_busy", busy_o, 1'b0);
    chk1("late_vld_out_vld", out_vld_o, 1'b0);
    chk1("late_vld_perm_rst", perm_rst_n_o, 1'b0);
    chk1("late_vld_state_zero", (pdin0 == '0) && (pdin1 == '0), 1'b1);

    // Three blocks with random input gaps and random output backpressure
    for (int i = 0; i < 2 * RATE + 5; i++) begin
      send_lane({$urandom, $urandom}, {$urandom, $urandom}, i == 2 * RATE + 4, 1'b1);
      if (i == RATE - 1 || i == 2 * RATE - 1 || i == 2 * RATE + 4) wait_perm();
    end
    model_push();
    recv_msg(0, 1'b1);

    chk_int("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keccak_masked_sponge.md
KECCAK_MASKED_SPONGE -- requirements
Module: keccak_masked_sponge

Interface
REQ-001 Parameter RATE_LANES, default 17, number of 64-bit rate lanes absorbed per block; legal range 1..24.
REQ-002 Parameter OUT_LANES, default 4, number of 64-bit lanes squeezed per message; legal range 1..RATE_LANES.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_vld_i  input  1  input lane valid.
REQ-006 in_rdy_o  output  1  input lane ready.
REQ-007 in_last_i  input  1  accepted lane is the final lane of the pre-padded message.
REQ-008 in_share0_i / in_share1_i  input  64 each  Boolean shares of the input lane.
REQ-009 out_vld_o  output  1  output lane valid.
REQ-010 out_rdy_i  input  1  output lane ready.
REQ-011 out_share0_o / out_share1_o  output  64 each  Boolean shares of the squeezed lane.
REQ-012 perm_rst_n_o  output  1  registered active-low reset for the permutation core; release starts a permutation.
REQ-013 perm_din_share0_o / perm_din_share1_o  output  1600 each  state shares to the permutation.
REQ-014 perm_dout_share0_i / perm_dout_share1_i  input  1600 each  permuted state shares.
REQ-015 perm_dout_vld_i  input  1  permutation result valid.
REQ-016 busy_o  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL hold two 1600-bit state registers, one per share; lane i occupies bits [64*i+63 : 64*i], i = x+5y.
REQ-018 perm_din_share0_o/perm_din_share1_o SHALL equal the share0/share1 state registers at all times.
REQ-019 The FSM SHALL have states IDLE, ABSORB, PERM, SQUEEZE.
REQ-020 in_rdy_o SHALL be 1 in IDLE and ABSORB, 0 in PERM and SQUEEZE.
REQ-021 On an accepted input beat (in_vld_i & in_rdy_o), lane cnt of share0 SHALL be XORed with in_share0_i and lane cnt of share1 with in_share1_i; shares are never combined with each other.
REQ-022 Lane counter cnt SHALL start at 0, increment per accepted beat, and return to 0 on entering PERM.
REQ-023 IDLE -> ABSORB on an accepted beat without in_last_i; IDLE/ABSORB -> PERM on an accepted beat with in_last_i or with cnt = RATE_LANES-1.
REQ-024 A last flag SHALL latch when in_last_i is accepted and clear on return to IDLE.
REQ-025 perm_rst_n_o SHALL be 0 in IDLE, ABSORB, SQUEEZE and 1 from the first cycle after entering PERM until perm_dout_vld_i is sampled high.
REQ-026 In PERM, while perm_rst_n_o = 1 and perm_dout_vld_i = 1, both state registers SHALL load perm_dout_share*_i, perm_rst_n_o SHALL go 0 next cycle, and the FSM SHALL go to SQUEEZE if last is set, else ABSORB.
REQ-027 perm_dout_vld_i SHALL be ignored outside PERM and while perm_rst_n_o = 0.
REQ-028 In SQUEEZE, out_vld_o = 1 and out_share*_o = lane cnt of the matching share; cnt increments per accepted beat (out_vld_o & out_rdy_i).
REQ-029 After the beat with cnt = OUT_LANES-1 is accepted, both state registers SHALL clear to zero, cnt to 0, and the FSM to IDLE.
REQ-030 out_vld_o SHALL hold and out_share*_o stay stable while out_rdy_i = 0.
REQ-031 In ABSORB, in_vld_i = 0 SHALL hold state and cnt unchanged indefinitely.
REQ-032 Padding is the caller's duty; lanes not written in a partial final block SHALL remain unchanged.

Reset
REQ-033 rst_n = 0 SHALL asynchronously force IDLE, cnt = 0, last = 0, both state registers = 0, perm_rst_n_o = 0, out_vld_o = 0, busy_o = 0, at any point including mid-PERM or mid-SQUEEZE.
REQ-034 After reset release, in_rdy_o SHALL be 1 in the first cycle.

Structure
REQ-035 Package keccak_pkg SHALL hold LANE_W = 64, STATE_W = 1600, NUM_LANES = 25, and the FSM state enum.
REQ-036 One sub-module, keccak_lane_rw, SHALL implement the indexed lane XOR-write and lane read for a single share, instantiated twice.

Verification
REQ-037 The bench SHALL stub the permutation: dout = din XOR 0xA5 replicated per share, vld pulse 24 cycles after perm_rst_n_o rises.
REQ-038 Reset: rst_n low -> in_rdy_o=1, out_vld_o=0, perm_rst_n_o=0, busy_o=0, state outputs all zero.
REQ-039 One lane with last, share0=0x06, share1=0x00 -> PERM; perm_rst_n_o high 24 cycles; SQUEEZE lane0 share0 = 0xA5A5...A5A3, share1 = 0xA5A5...A5A5.
REQ-040 17 lanes without last -> PERM after beat 17; then ABSORB with cnt=0, in_rdy_o=1, perm_rst_n_o=0.
REQ-041 SQUEEZE with out_rdy_i low 10 cycles -> out_vld_o held, data stable; 4 accepted beats -> IDLE, state zero.
REQ-042 rst_n pulsed low at PERM cycle 12 -> IDLE, perm_rst_n_o=0, late perm_dout_vld_i ignored.
REQ-043 Random in_vld_i gaps (50%) over 3 blocks -> squeezed shares XOR to the reference-model digest.
